// File: rtl/hex_ascii_streamer.sv
// hex_ascii_streamer: streams a word as uppercase ASCII hex, MSB nibble first, optional CR LF
module hex_ascii_streamer #(
    parameter int NIBBLES     = 8,
    parameter bit APPEND_CRLF = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4*NIBBLES-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);
    localparam int W = 4 * NIBBLES;

    typedef enum logic [1:0] {IDLE, HEX, CR, LF} state_t;

    state_t         state, next_state;
    logic [W-1:0]   shift, shifted;
    logic [3:0]     count;
    logic           fire;

    function automatic logic [7:0] ascii(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
    endfunction

    assign shifted = shift << 4;
    assign fire    = out_valid && out_ready;

    // State register; reset discards any partially sent word
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic: digits, then optional CR and LF, then back to IDLE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = HEX;
            HEX:     if (fire && count == 4'd0) next_state = APPEND_CRLF ? CR : IDLE;
            CR:      if (fire) next_state = LF;
            LF:      if (fire) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake flags depend on state alone; every non-IDLE state holds a valid byte
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = !in_ready;
        out_valid = busy;
    end

    // Datapath: latch word, walk nibbles on each output handshake, register the next character
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift    <= '0;
            count    <= 4'd0;
            out_data <= 8'h00;
        end else if (state == IDLE) begin
            if (in_valid) begin
                shift    <= in_data;
                count    <= 4'(NIBBLES - 1);
                out_data <= ascii(in_data[W-1 -: 4]);
            end
        end else if (state == HEX) begin
            if (fire && count != 4'd0) begin
                shift    <= shifted;
                count    <= count - 4'd1;
                out_data <= ascii(shifted[W-1 -: 4]);
            end else if (fire && APPEND_CRLF) begin
                out_data <= 8'h0D;
            end
        end else if (state == CR) begin
            if (fire) out_data <= 8'h0A;
        end
    end
endmodule
